// File: rtl/memory_frontend_pkg.sv
// Shared types and helpers for the memory frontend: funct3 and FSM encodings,
// lane widths, and request classification functions.
package memory_frontend_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        FUNCT3_B  = 3'b000,
        FUNCT3_H  = 3'b001,
        FUNCT3_W  = 3'b010,
        FUNCT3_BU = 3'b100,
        FUNCT3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MERGE = 2'd2,
        WRITE = 2'd3
    } state_e;

    function automatic logic funct3_valid(input logic [2:0] f3);
        case (f3)
            FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // Halfwords must sit on an even byte, words on a word boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            FUNCT3_H, FUNCT3_HU: return off[0];
            FUNCT3_W:            return (off != 2'b00);
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_frontend_lane_formatter.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// sub-word store merge into the word read from the backend.
module lane_formatter
    import memory_frontend_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [WORD_W-1:0] rdata_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_data_o,
    output logic [WORD_W-1:0] merge_data_o
);

    logic [BYTE_W-1:0] byte_s;
    logic [HALF_W-1:0] half_s;

    // Halfword lane choice uses only offset bit 1, so low-bit misalignment is ignored.
    always_comb begin
        byte_s = rdata_i[{offset_i, 3'b000} +: BYTE_W];
        half_s = offset_i[1] ? rdata_i[WORD_W-1:HALF_W] : rdata_i[HALF_W-1:0];
    end

    always_comb begin
        load_data_o = {WORD_W{1'b0}};
        case (funct3_i)
            FUNCT3_B:  load_data_o = {{(WORD_W-BYTE_W){byte_s[BYTE_W-1]}}, byte_s};
            FUNCT3_BU: load_data_o = {{(WORD_W-BYTE_W){1'b0}}, byte_s};
            FUNCT3_H:  load_data_o = {{(WORD_W-HALF_W){half_s[HALF_W-1]}}, half_s};
            FUNCT3_HU: load_data_o = {{(WORD_W-HALF_W){1'b0}}, half_s};
            FUNCT3_W:  load_data_o = rdata_i;
            default:   load_data_o = {WORD_W{1'b0}};
        endcase
    end

    // Replace only the addressed lanes; all other lanes keep the backend value.
    always_comb begin
        merge_data_o = rdata_i;
        case (funct3_i)
            FUNCT3_B, FUNCT3_BU: merge_data_o[{offset_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
            FUNCT3_H, FUNCT3_HU: begin
                if (offset_i[1]) begin
                    merge_data_o[WORD_W-1:HALF_W] = wdata_i[HALF_W-1:0];
                end else begin
                    merge_data_o[HALF_W-1:0] = wdata_i[HALF_W-1:0];
                end
            end
            FUNCT3_W: merge_data_o = wdata_i;
            default:  merge_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_frontend.sv
// Core-side load/store initiator for a word-addressed backend with 1-cycle read latency.
// Optional misalignment trap: define MEMORY_FRONTEND_MISALIGN_TRAP_EN.
module memory_frontend
    import memory_frontend_pkg::*;
#(
    parameter int BACKEND_ADDR_WIDTH = 30
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          reqValid,
    output logic                          reqReady,
    input  logic                          reqWrite,
    input  logic [2:0]                    reqFunct3,
    input  logic [31:0]                   reqAddress,
    input  logic [31:0]                   reqStoreData,
    output logic                          done,
    output logic [31:0]                   loadData,
    output logic                          misaligned,
    output logic [BACKEND_ADDR_WIDTH-1:0] backendAddress,
    input  logic [31:0]                   backendDataOut,
    output logic [31:0]                   backendDataIn,
    output logic                          backendWriteEnable
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] load_q, load_d;
    logic        done_q, done_d;
`ifdef MEMORY_FRONTEND_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`endif

    logic        accept_s;
    logic [31:0] fmt_load_s;
    logic [31:0] fmt_merge_s;

    lane_formatter u_fmt (
        .funct3_i     (funct3_q),
        .offset_i     (addr_q[1:0]),
        .rdata_i      (backendDataOut),
        .wdata_i      (sdata_q),
        .load_data_o  (fmt_load_s),
        .merge_data_o (fmt_merge_s)
    );

    assign accept_s = reqValid & (state_q == IDLE);

    // Next-state and datapath register updates for the request FSM.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        sdata_d  = sdata_q;
        word_d   = word_q;
        load_d   = load_q;
        done_d   = 1'b0;
`ifdef MEMORY_FRONTEND_MISALIGN_TRAP_EN
        mis_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    addr_d   = reqAddress;
                    funct3_d = reqFunct3;
                    write_d  = reqWrite;
                    sdata_d  = reqStoreData;
                    if (!funct3_valid(reqFunct3)) begin
                        done_d = 1'b1;
                        if (!reqWrite) begin
                            load_d = 32'h0000_0000;
                        end else begin
                            load_d = load_q;
                        end
                    end
`ifdef MEMORY_FRONTEND_MISALIGN_TRAP_EN
                    else if (is_misaligned(reqFunct3, reqAddress[1:0])) begin
                        done_d = 1'b1;
                        mis_d  = 1'b1;
                    end
`endif
                    else if (reqWrite && (reqFunct3 == FUNCT3_W)) begin
                        word_d  = reqStoreData;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                state_d = MERGE;
            end
            MERGE: begin
                if (write_q) begin
                    word_d  = fmt_merge_s;
                    state_d = WRITE;
                end else begin
                    load_d  = fmt_load_s;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0000_0000;
            funct3_q <= 3'b000;
            write_q  <= 1'b0;
            sdata_q  <= 32'h0000_0000;
            word_q   <= 32'h0000_0000;
            load_q   <= 32'h0000_0000;
            done_q   <= 1'b0;
`ifdef MEMORY_FRONTEND_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            sdata_q  <= sdata_d;
            word_q   <= word_d;
            load_q   <= load_d;
            done_q   <= done_d;
`ifdef MEMORY_FRONTEND_MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

    // The strobe is gated by reset so a write pending in the reset cycle never lands.
    assign backendWriteEnable = (state_q == WRITE) & ~reset;
    assign backendAddress     = addr_q[BACKEND_ADDR_WIDTH+1:2];
    assign backendDataIn      = word_q;
    assign reqReady           = (state_q == IDLE);
    assign done               = done_q;
    assign loadData           = load_q;
`ifdef MEMORY_FRONTEND_MISALIGN_TRAP_EN
    assign misaligned         = mis_q;
`else
    assign misaligned         = 1'b0;
`endif

endmodule

// File: tb/tb_memory_frontend.sv
// Scoreboard-based bench for memory_frontend with a 1-cycle-latency backend model.
module tb_memory_frontend;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [2:0]  reqFunct3 = 3'b000;
    logic [31:0] reqAddress = 32'h0;
    logic [31:0] reqStoreData = 32'h0;
    logic        done;
    logic [31:0] loadData;
    logic        misaligned;
    logic [29:0] backendAddress;
    logic [31:0] backendDataOut;
    logic [31:0] backendDataIn;
    logic        backendWriteEnable;

    typedef struct {
        logic [31:0] data;
        int          lat;
        logic        mis;
        int          writes;
    } exp_t;

    typedef struct packed {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } req_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    int          we_cycles = 0;
    int          acc_cnt = 0;
    logic [29:0] last_wa = 30'h0;
    logic [31:0] last_wd = 32'h0;

    memory_frontend #(.BACKEND_ADDR_WIDTH(30)) dut (
        .clock              (clock),
        .reset              (reset),
        .reqValid           (reqValid),
        .reqReady           (reqReady),
        .reqWrite           (reqWrite),
        .reqFunct3          (reqFunct3),
        .reqAddress         (reqAddress),
        .reqStoreData       (reqStoreData),
        .done               (done),
        .loadData           (loadData),
        .misaligned         (misaligned),
        .backendAddress     (backendAddress),
        .backendDataOut     (backendDataOut),
        .backendDataIn      (backendDataIn),
        .backendWriteEnable (backendWriteEnable)
    );

    always #5 clock = ~clock;

    // Synchronous-read backend memory plus accept/write bookkeeping.
    always @(posedge clock) begin
        backendDataOut <= mem[backendAddress[9:0]];
        if (backendWriteEnable) begin
            mem[backendAddress[9:0]] <= backendDataIn;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= backendAddress;
            last_wd <= backendDataIn;
        end
        if (reqValid && reqReady) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clock) begin
        if (backendWriteEnable) we_cycles <= we_cycles + 1;
    end

    // Issue one request and observe it; lat = index of the cycle after accept in which done is high.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output logic [31:0] ld,
                           output logic m, output int wr);
        int guard;
        int wr0;
        reqWrite = w; reqFunct3 = f3; reqAddress = a; reqStoreData = d; reqValid = 1'b1;
        guard = 0;
        while (!reqReady && guard < 20) begin @(posedge clock); #1; guard++; end
        wr0 = wr_cnt;
        @(posedge clock); #1;
        reqValid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(posedge clock); #1; lat++; end
        ld = loadData; m = misaligned; wr = wr_cnt - wr0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", reqReady); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        n_cmp++; if (backendWriteEnable !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", backendWriteEnable); end
        n_cmp++; if (loadData !== 32'h0) begin n_bad++; $display("FAIL reset_load: got %h want 0", loadData); end
        n_cmp++; if (backendAddress !== 30'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", backendAddress); end
        n_cmp++; if (backendDataIn !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h want 0", backendDataIn); end
        reset = 1'b0;
    endtask

    task automatic test_word_store();
        int lat; logic [31:0] ld; logic m; int wr; exp_t e;
        sb.push_back('{data: 32'h0, lat: 2, mis: 1'b0, writes: 1});
        run_req(1'b1, 3'b010, 32'h100, 32'h8899AABB, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL sw_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (ld !== e.data) begin n_bad++; $display("FAIL sw_loaddata: got %h want %h", ld, e.data); end
        n_cmp++; if (wr !== e.writes) begin n_bad++; $display("FAIL sw_writes: got %0d want %0d", wr, e.writes); end
        n_cmp++; if (last_wa !== 30'h40 || last_wd !== 32'h8899AABB) begin
            n_bad++; $display("FAIL sw_wdata: got %h@%h want 8899aabb@40", last_wd, last_wa); end
    endtask

    task automatic test_loads();
        req_t tbl [0:7];
        int lat; logic [31:0] ld; logic m; int wr; exp_t e;
        tbl[0] = '{1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA};
        tbl[1] = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h00000088};
        tbl[2] = '{1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899};
        tbl[3] = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h0000AABB};
        tbl[4] = '{1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFBB};
        tbl[5] = '{1'b0, 3'b100, 32'h102, 32'h0, 32'h00000099};
        tbl[6] = '{1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFFAABB};
        tbl[7] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB};
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{data: tbl[i].exp, lat: 3, mis: 1'b0, writes: 0});
            run_req(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].d, lat, ld, m, wr);
            e = sb.pop_front();
            n_cmp++; if (ld !== e.data) begin n_bad++; $display("FAIL load%0d_data: got %h want %h", i, ld, e.data); end
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL load%0d_latency: got %0d want %0d", i, lat, e.lat); end
            n_cmp++; if (wr !== e.writes || m !== e.mis) begin
                n_bad++; $display("FAIL load%0d_side: writes %0d mis %b want %0d %b", i, wr, m, e.writes, e.mis); end
        end
    endtask

    task automatic test_subword_store();
        int lat; logic [31:0] ld; logic m; int wr; exp_t e;
        sb.push_back('{data: 32'h8899AABB, lat: 4, mis: 1'b0, writes: 1});
        run_req(1'b1, 3'b000, 32'h102, 32'h12345677, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL sb_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (wr !== e.writes) begin n_bad++; $display("FAIL sb_writes: got %0d want %0d", wr, e.writes); end
        n_cmp++; if (ld !== e.data) begin n_bad++; $display("FAIL sb_loaddata: got %h want %h", ld, e.data); end
        n_cmp++; if (last_wa !== 30'h40 || last_wd !== 32'h8877AABB) begin
            n_bad++; $display("FAIL sb_merge: got %h@%h want 8877aabb@40", last_wd, last_wa); end
        sb.push_back('{data: 32'h8877AABB, lat: 3, mis: 1'b0, writes: 0});
        run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (ld !== e.data) begin n_bad++; $display("FAIL sb_readback: got %h want %h", ld, e.data); end
    endtask

    task automatic test_reset_in_write();
        int wr0; int lat; logic [31:0] ld; logic m; int wr; exp_t e;
        wr0 = wr_cnt;
        reqWrite = 1'b1; reqFunct3 = 3'b001; reqAddress = 32'h100; reqStoreData = 32'h00005555;
        reqValid = 1'b1;
        @(posedge clock); #1;
        reqValid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (backendWriteEnable !== 1'b0) begin n_bad++; $display("FAIL rst_write_we: got %b want 0", backendWriteEnable); end
        @(posedge clock); #1;
        reset = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_write_done: got %b want 0", done); end
        n_cmp++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL rst_write_idle: got %b want 1", reqReady); end
        n_cmp++; if (wr_cnt !== wr0) begin n_bad++; $display("FAIL rst_write_commit: got %0d writes want 0", wr_cnt - wr0); end
        sb.push_back('{data: 32'h8877AABB, lat: 3, mis: 1'b0, writes: 0});
        run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (ld !== e.data) begin n_bad++; $display("FAIL rst_write_mem: got %h want %h", ld, e.data); end
    endtask

    task automatic test_invalid_funct3();
        int lat; logic [31:0] ld; logic m; int wr; exp_t e;
        sb.push_back('{data: 32'h0, lat: 1, mis: 1'b0, writes: 0});
        run_req(1'b0, 3'b011, 32'h100, 32'h0, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (ld !== e.data) begin n_bad++; $display("FAIL inv_load_data: got %h want %h", ld, e.data); end
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL inv_load_latency: got %0d want %0d", lat, e.lat); end
        sb.push_back('{data: 32'h0, lat: 1, mis: 1'b0, writes: 0});
        run_req(1'b1, 3'b111, 32'h100, 32'hFFFFFFFF, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (wr !== e.writes) begin n_bad++; $display("FAIL inv_store_writes: got %0d want %0d", wr, e.writes); end
        n_cmp++; if (lat !== e.lat || m !== e.mis) begin
            n_bad++; $display("FAIL inv_store_done: lat %0d mis %b want %0d %b", lat, m, e.lat, e.mis); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] ld; logic m; int wr; exp_t e;
`ifdef MEMORY_FRONTEND_MISALIGN_TRAP_EN
        sb.push_back('{data: 32'h0, lat: 1, mis: 1'b1, writes: 0});
        sb.push_back('{data: 32'h0, lat: 1, mis: 1'b1, writes: 0});
`else
        sb.push_back('{data: 32'h8877AABB, lat: 3, mis: 1'b0, writes: 0});
        sb.push_back('{data: 32'hFFFFAABB, lat: 3, mis: 1'b0, writes: 0});
`endif
        run_req(1'b0, 3'b010, 32'h102, 32'h0, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (ld !== e.data) begin n_bad++; $display("FAIL mis_lw_data: got %h want %h", ld, e.data); end
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL mis_lw_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (m !== e.mis) begin n_bad++; $display("FAIL mis_lw_flag: got %b want %b", m, e.mis); end
        run_req(1'b0, 3'b001, 32'h101, 32'h0, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (ld !== e.data || m !== e.mis) begin
            n_bad++; $display("FAIL mis_lh: data %h mis %b want %h %b", ld, m, e.data, e.mis); end
    endtask

    task automatic test_back_to_back();
        int acc0; int we0; int lat; logic [31:0] ld; logic m; int wr; exp_t e;
        acc0 = acc_cnt; we0 = we_cycles;
        sb.push_back('{data: 32'h0, lat: 2, mis: 1'b0, writes: 1});
        sb.push_back('{data: 32'hDEADBEEF, lat: 3, mis: 1'b0, writes: 0});
        reqWrite = 1'b1; reqFunct3 = 3'b010; reqAddress = 32'h200; reqStoreData = 32'hDEADBEEF;
        reqValid = 1'b1;
        @(posedge clock); #1;
        reqWrite = 1'b0; reqAddress = 32'h200; reqStoreData = 32'h0;
        lat = 1;
        while (!done && lat < 20) begin @(posedge clock); #1; lat++; end
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_sw_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (we_cycles - we0 !== e.writes) begin
            n_bad++; $display("FAIL b2b_we_cycles: got %0d want %0d", we_cycles - we0, e.writes); end
        n_cmp++; if (acc_cnt - acc0 !== 1) begin n_bad++; $display("FAIL b2b_hold_accepts: got %0d want 1", acc_cnt - acc0); end
        n_cmp++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_done: got %b want 1", reqReady); end
        @(posedge clock); #1;
        reqValid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(posedge clock); #1; lat++; end
        e = sb.pop_front();
        n_cmp++; if (loadData !== e.data) begin n_bad++; $display("FAIL b2b_lw_data: got %h want %h", loadData, e.data); end
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_lw_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (acc_cnt - acc0 !== 2) begin n_bad++; $display("FAIL b2b_total_accepts: got %0d want 2", acc_cnt - acc0); end
        @(posedge clock); #1;
        sb.push_back('{data: 32'hDEADBEEF, lat: 4, mis: 1'b0, writes: 1});
        run_req(1'b1, 3'b001, 32'h202, 32'h1234CAFE, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (last_wd !== 32'hCAFEBEEF || wr !== e.writes) begin
            n_bad++; $display("FAIL sh_merge: got %h (%0d writes) want cafebeef (1)", last_wd, wr); end
        n_cmp++; if (lat !== e.lat || ld !== e.data) begin
            n_bad++; $display("FAIL sh_done: lat %0d data %h want %0d %h", lat, ld, e.lat, e.data); end
        sb.push_back('{data: 32'hFFFFCAFE, lat: 3, mis: 1'b0, writes: 0});
        run_req(1'b0, 3'b001, 32'h202, 32'h0, lat, ld, m, wr);
        e = sb.pop_front();
        n_cmp++; if (ld !== e.data) begin n_bad++; $display("FAIL lh_after_sh: got %h want %h", ld, e.data); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_subword_store();
        test_reset_in_write();
        test_invalid_funct3();
        test_misalign();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_frontend.md
Name: memory_frontend

Overview:
Core-side initiator for the word-addressed memory backend. Accepts byte/halfword/word load and store requests using RISC-V funct3 encoding. Issues word accesses on the backend read/write port, accounting for the backend's one-cycle synchronous read latency. Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores.

Parameters:
BACKEND_ADDR_WIDTH, 30, width of backendAddress (word address = byte address [31:2]).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
reqValid  input  1  request present
reqReady  output  1  frontend idle, will accept request this cycle
reqWrite  input  1  1 = store, 0 = load
reqFunct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
reqAddress  input  32  byte address
reqStoreData  input  32  store data, LSB-aligned
done  output  1  one-cycle pulse, request complete
loadData  output  32  formatted load result, valid when done
misaligned  output  1  valid with done; misaligned access flagged
backendAddress  output  BACKEND_ADDR_WIDTH  word address to backend
backendDataOut  input  32  backend read data, valid cycle after address presented
backendDataIn  output  32  backend write data
backendWriteEnable  output  1  backend write strobe

Behaviour:
- One clock (clock); reset is synchronous and active-high (reset).
- Reset values: state IDLE; done, misaligned, backendWriteEnable = 0; loadData, backendDataIn, backendAddress and latched request = 0.
- Byte lanes: lane n = bits [8n+7:8n], selected by address[1:0].
- reqReady = 1 only in IDLE.
- Accept = reqValid & reqReady. On accept, latch address, funct3, write flag and store data.
- reqValid while busy is ignored; the requester holds the request.
- States:
  - IDLE: on accept, go to READ for load or sub-word store, and to WRITE for word store.
  - READ: drive backendAddress = latched addr[31:2]; no write. Next state: MERGE.
  - MERGE: backendDataOut is valid.
    - Load: register the extracted and extended value into loadData, pulse done next cycle, return to IDLE.
    - Sub-word store: register the merged word (selected lanes replaced by reqStoreData low byte/halfword, other lanes preserved). Next state: WRITE.
  - WRITE: backendWriteEnable = 1, backendDataIn = word; go to IDLE, done pulses next cycle.
- backendAddress holds the latched word address in all states.
- Latency from accept edge to done high:
  - load: 3 cycles
  - word store: 2 cycles
  - sub-word store: 4 cycles
- A new request may be accepted in the same cycle done is high.
- Sign extension:
  - B/H: replicate bit 7/15.
  - BU/HU: zero-fill.
  - Halfword uses address[1] (lanes 0-1 or 2-3).
- Invalid funct3 (011, 110, 111):
  - Accepted; no backend access.
  - done pulses 1 cycle after accept.
  - loadData = 0, no write.
- Stores leave loadData unchanged.
- reset asserted in any state returns to IDLE next edge.
- backendWriteEnable is gated by ~reset, so a write scheduled in the reset cycle is not committed.

Optional Feature:
Macro: MEMORY_FRONTEND_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠00, is accepted with no backend access.
  - done and misaligned = 1 pulse 1 cycle after accept; loadData unchanged.
- Undefined:
  - misaligned is tied 0.
  - Offending low address bits are ignored: halfword uses addr[1]; word ignores addr[1:0].

Decomposition:
- Package memory_frontend_pkg:
  - funct3 enum (FUNCT3_B, _H, _W, _BU, _HU)
  - state enum (IDLE, READ, MERGE, WRITE)
  - lane-width constants
- One sub-module, lane_formatter (combinational):
  - extract/extend for loads
  - merge for stores
  - shared by MERGE logic

Test Plan:
- Preload word 0x40 = 0x8899AABB. LB @0x101 → done 3 cycles after accept, loadData 0xFFFFFFAA. LBU @0x103 → 0x00000088.
- Same word: LH @0x102 → 0xFFFF8899. LHU @0x100 → 0x0000AABB. LW @0x100 → 0x8899AABB.
- SB @0x102 data 0x12345677 → one backend write of 0x8877AABB at word 0x40, done 4 cycles after accept; LW then returns 0x8877AABB.
- SW @0x200 data 0xDEADBEEF → backendWriteEnable high exactly 1 cycle, done 2 cycles after accept. A second reqValid held during the busy cycles is accepted only once reqReady returns.
- SH @0x100 with reset asserted in the WRITE cycle → backendWriteEnable stays 0, memory unchanged, state IDLE, done 0.
- With MISALIGN_TRAP_EN: LW @0x102 → no backend read, done and misaligned 1 cycle after accept. Without it: same request returns the word at 0x100.
